// File: rtl/denormalize.sv
// Sequential right-shift aligner: shifts a mantissa right one bit per clock and
// returns the aligned mantissa together with guard, round and sticky bits.
module denormalize #(
    parameter int WIDTH   = 4,
    parameter int SHIFT_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_mantissa,
    input  logic [SHIFT_W-1:0] in_shift,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_mantissa,
    output logic               out_guard,
    output logic               out_round,
    output logic               out_sticky
);
    localparam int EXT_W = WIDTH + 2;
    localparam int CNT_W = $clog2(EXT_W + 1);
    localparam logic [SHIFT_W-1:0] MAX_SHIFT = SHIFT_W'(EXT_W);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state, state_next;
    logic [EXT_W-1:0]   ext;
    logic               sticky;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   clamped;
    logic               accept;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    // Beyond WIDTH+2 every bit is already in sticky, so longer shifts saturate.
    assign clamped = (in_shift >= MAX_SHIFT) ? CNT_W'(EXT_W) : CNT_W'(in_shift);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)      state_next = SHIFT;
            SHIFT:   if (count == '0) state_next = DONE;
            DONE:    if (out_ready)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            ext          <= '0;
            sticky       <= 1'b0;
            count        <= '0;
            out_mantissa <= '0;
            out_guard    <= 1'b0;
            out_round    <= 1'b0;
            out_sticky   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        ext    <= {in_mantissa, 2'b00};
                        sticky <= 1'b0;
                        count  <= clamped;
                    end
                end
                SHIFT: begin
                    if (count != '0) begin
                        sticky <= sticky | ext[0];
                        ext    <= ext >> 1;
                        count  <= count - CNT_W'(1);
                    end else begin
                        // Result registers only change on entry to DONE, so they
                        // hold the last result while the next request shifts.
                        out_mantissa <= ext[EXT_W-1:2];
                        out_guard    <= ext[1];
                        out_round    <= ext[0];
                        out_sticky   <= sticky;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_denormalize.sv
// Directed bench for denormalize with a per-cycle reference model built from
// plain shift arithmetic and a latency countdown.
module tb_denormalize;
    localparam int WIDTH   = 4;
    localparam int SHIFT_W = 8;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [WIDTH-1:0]   in_mantissa = '0;
    logic [SHIFT_W-1:0] in_shift = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [WIDTH-1:0]   out_mantissa;
    logic               out_guard, out_round, out_sticky;

    int checks = 0;
    int passed = 0;

    denormalize #(.WIDTH(WIDTH), .SHIFT_W(SHIFT_W)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mantissa(in_mantissa), .in_shift(in_shift),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mantissa(out_mantissa), .out_guard(out_guard),
        .out_round(out_round), .out_sticky(out_sticky)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Expected {mantissa, guard, round, sticky} from arithmetic on the full value.
    function automatic logic [WIDTH+2:0] expect_result(input logic [WIDTH-1:0] m,
                                                      input int unsigned s);
        int unsigned n, full, res;
        logic st;
        n    = (s > WIDTH + 2) ? WIDTH + 2 : s;
        full = int'(m) * 4;
        res  = full >> n;
        st   = (full % (1 << n)) != 0;
        return {res[WIDTH+1:0], st};
    endfunction

    // Reference model: busy countdown to the valid cycle plus the held result.
    logic             m_busy = 1'b0, m_valid = 1'b0;
    int               m_wait = 0;
    logic [WIDTH+2:0] m_pend = '0, m_out = '0;

    always @(posedge clock) begin
        if (reset) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_out   <= '0;
        end else if (m_valid) begin
            if (out_ready) m_valid <= 1'b0;
        end else if (m_busy) begin
            if (m_wait == 1) begin
                m_busy  <= 1'b0;
                m_valid <= 1'b1;
                m_out   <= m_pend;
            end
            m_wait <= m_wait - 1;
        end else if (in_valid) begin
            m_busy <= 1'b1;
            m_wait <= 1 + ((int'(in_shift) > WIDTH + 2) ? WIDTH + 2 : int'(in_shift));
            m_pend <= expect_result(in_mantissa, int'(in_shift));
        end
    end

    always @(negedge clock) begin
        check("cyc_in_ready",  int'(in_ready),  int'(!m_busy && !m_valid));
        check("cyc_out_valid", int'(out_valid), int'(m_valid));
        check("cyc_result", int'({out_mantissa, out_guard, out_round, out_sticky}),
              int'(m_out));
    end

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
        if (!out_valid) check("timeout_out_valid", 0, 1);
    endtask

    task automatic run(input string name, input logic [WIDTH-1:0] m, input int s,
                       input logic [WIDTH-1:0] em, input logic eg, er, es,
                       input int lat);
        int cyc;
        @(negedge clock);
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        in_mantissa = m;
        in_shift    = SHIFT_W'(s);
        @(negedge clock);
        in_valid    = 1'b0;
        in_mantissa = 4'b1111;
        in_shift    = 8'd1;
        wait_valid(cyc);
        check({name, "_latency"}, cyc, lat);
        check({name, "_mantissa"}, int'(out_mantissa), int'(em));
        check({name, "_grs"}, int'({out_guard, out_round, out_sticky}),
              int'({eg, er, es}));
        @(negedge clock);
        check({name, "_ready_after"}, int'(in_ready), 1);
    endtask

    initial begin
        int cyc;
        repeat (2) @(negedge clock);
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_data", int'({out_mantissa, out_guard, out_round, out_sticky}), 0);
        reset = 1'b0;

        run("shift0",   4'b0101, 0,   4'b0101, 0, 0, 0, 1);
        run("shift1",   4'b0101, 1,   4'b0010, 1, 0, 0, 2);
        run("shift3",   4'b0101, 3,   4'b0000, 1, 0, 1, 4);
        run("shift255", 4'b0001, 255, 4'b0000, 0, 0, 1, 7);
        run("shift2",   4'b1111, 2,   4'b0011, 1, 1, 0, 3);
        run("shift5",   4'b1111, 5,   4'b0000, 0, 1, 1, 6);
        run("shift6",   4'b1000, 6,   4'b0000, 0, 0, 1, 7);
        run("shift7",   4'b1001, 7,   4'b0000, 0, 0, 1, 7);
        run("zero",     4'b0000, 255, 4'b0000, 0, 0, 0, 7);

        // Consumer stall in DONE with a competing request pending.
        @(negedge clock);
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        in_mantissa = 4'b1011;
        in_shift    = 8'd2;
        @(negedge clock);
        in_mantissa = 4'b0111;
        in_shift    = 8'd0;
        wait_valid(cyc);
        check("stall_latency", cyc, 3);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", int'(out_valid), 1);
            check("stall_in_ready", int'(in_ready), 0);
            check("stall_data", int'({out_mantissa, out_guard, out_round, out_sticky}),
                  int'(8'b0010_1_1_0));
            @(negedge clock);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clock);
        check("stall_ready_after", int'(in_ready), 1);
        check("stall_valid_after", int'(out_valid), 0);

        // Reset in the middle of a shift discards the request.
        in_valid    = 1'b1;
        in_mantissa = 4'b0101;
        in_shift    = 8'd3;
        @(negedge clock);
        in_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midreset_in_ready", int'(in_ready), 1);
        check("midreset_out_valid", int'(out_valid), 0);
        check("midreset_data", int'({out_mantissa, out_guard, out_round, out_sticky}), 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            check("midreset_no_result", int'(out_valid), 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
